// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the ID/EX register, the M-extension unit and the EX/MEM register.
// The issuer (master) drives the operands and pipeline controls; the unit (slave) returns result, tag, valid and busy.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      rd_i;
  logic            flush;
  logic            stall_in;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_o;
  logic            valid;
  logic            busy;

  modport master (
    output start, funct3, src_a, src_b, rd_i, flush, stall_in,
    input  result, rd_o, valid, busy
  );

  modport slave (
    input  start, funct3, src_a, src_b, rd_i, flush, stall_in,
    output result, rd_o, valid, busy
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M mul/div: 33-cycle latency (1 for div special cases, and for multiplies when FAST_MUL_EN is defined).
// A finished result is held in DONE while stall_in is high; flush aborts to IDLE with no valid.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  ex_muldiv_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [XLEN-1:0]   r_opa, r_opb, r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg, r_valid, r_busy;

  logic              w_is_div, w_sgn_a, w_sgn_b, w_neg, w_div0, w_ovf;
  logic [XLEN-1:0]   w_opa, w_opb, w_special;

  always_comb begin
    w_is_div  = bus.funct3[2];
    w_sgn_a   = bus.src_a[XLEN-1] && (bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    w_sgn_b   = bus.src_b[XLEN-1] && (bus.funct3 inside {3'b001, 3'b100, 3'b110});
    w_opa     = w_sgn_a ? -bus.src_a : bus.src_a;
    w_opb     = w_sgn_b ? -bus.src_b : bus.src_b;
    // Remainder follows the dividend; everything else negates when signs differ.
    w_neg     = (bus.funct3 == 3'b110) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
    w_div0    = w_is_div && (bus.src_b == '0);
    w_ovf     = w_is_div && !bus.funct3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
    w_special = bus.funct3[1] ? (w_div0 ? bus.src_a : '0) : (w_div0 ? '1 : MIN_NEG);
  end

`ifdef FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN+1:0] w_fprod;
  logic [XLEN-1:0]          w_fast;

  always_comb begin
    w_fa    = {(bus.funct3[1:0] == 2'b11) ? 1'b0 : bus.src_a[XLEN-1], bus.src_a};
    w_fb    = {(bus.funct3[1:0] == 2'b01) ? bus.src_b[XLEN-1] : 1'b0, bus.src_b};
    w_fprod = w_fa * w_fb;
    w_fast  = (bus.funct3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
  end
`endif

  // One step of shift-add (acc = {partial, multiplier}) or restoring divide (acc = {rem, dividend}).
  logic [XLEN:0]     w_mul_sum, w_div_sh;
  logic [XLEN-1:0]   w_div_sub, w_qr, w_final;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;

  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_ge  = w_div_sh >= {1'b0, r_opb};
    w_div_sub = w_div_sh[XLEN-1:0] - r_opb;
    w_div_nxt = {w_div_ge ? w_div_sub : w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], w_div_ge};
    w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
    w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_qr      = r_op[1] ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];
    if (r_op[2])
      w_final = r_neg ? -w_qr : w_qr;
    else
      w_final = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            r_op   <= bus.funct3;
            r_rd   <= bus.rd_i;
            r_opa  <= w_opa;
            r_opb  <= w_opb;
            r_neg  <= w_neg;
            r_cnt  <= '0;
            r_acc  <= {{XLEN{1'b0}}, w_is_div ? w_opa : w_opb};
            r_busy <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
`ifdef FAST_MUL_EN
            else if (!w_is_div) begin
              r_result <= w_fast;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
`endif
            else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
              r_result <= w_final;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.flush || !bus.stall_in) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.rd_o   = r_rd;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboarded random and directed bench for ex_muldiv against an arithmetic RV32M reference.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();
  ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'b000: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Monitor: a result transfers when valid is seen without stall or flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.valid && !bus.stall_in && !bus.flush) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %h with no pending op", bus.result);
        end else begin
          e = sb_q.pop_front();
          check("result", bus.result, e.res);
          check("rd_o", {27'h0, bus.rd_o}, {27'h0, e.rd});
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int stall_n);
    int          lat;
    logic [31:0] er;
    er = ref_model(f, a, b);
    wait_idle();
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.rd_i   = rd;
    sb_q.push_back({er, rd});
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat(f, a, b)));
    if (stall_n > 0) begin
      bus.stall_in = 1'b1;
      repeat (stall_n) begin
        // A competing request during DONE must not disturb the held result.
        bus.start  = 1'b1;
        bus.funct3 = 3'b011;
        bus.src_a  = $urandom;
        bus.src_b  = $urandom;
        bus.rd_i   = ~rd;
        @(posedge clk); #1;
        check("stall_valid", {31'h0, bus.valid}, 32'h1);
        check("stall_result", bus.result, er);
        check("stall_rd", {27'h0, bus.rd_o}, {27'h0, rd});
      end
      bus.stall_in = 1'b0;
      @(posedge clk); #1;
      check("post_stall_busy", {31'h0, bus.busy}, 32'h0);
      check("post_stall_valid", {31'h0, bus.valid}, 32'h0);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("start_in_done_ignored", {31'h0, bus.busy}, 32'h0);
    end
  endtask

  task automatic rand_operand(output logic [31:0] v);
    case ($urandom_range(0, 3))
      0: v = $urandom_range(0, 200);
      1: case ($urandom_range(0, 3))
           0: v = 32'h0;
           1: v = 32'h8000_0000;
           2: v = 32'hFFFF_FFFF;
           default: v = 32'h1;
         endcase
      default: v = $urandom;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic        seen;
    bus.start = 1'b0; bus.funct3 = '0; bus.src_a = '0; bus.src_b = '0;
    bus.rd_i = '0; bus.flush = 1'b0; bus.stall_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {31'h0, bus.valid}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_rd", {27'h0, bus.rd_o}, 32'h0);

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    issue(3'b010, 32'hFFFF_FFFF, 32'h2, 5'd3, 0);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 0);

    // Reset in the middle of a divide.
    wait_idle();
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.rd_i = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_valid", {31'h0, bus.valid}, 32'h0);
    check("midrun_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("midrun_rst_result", bus.result, 32'h0);
    check("midrun_rst_rd", {27'h0, bus.rd_o}, 32'h0);
    issue(3'b101, 32'd100, 32'd7, 5'd9, 0);

    issue(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd10, 0);
    issue(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd11, 0);
    issue(3'b100, 32'd5, 32'd0, 5'd12, 0);
    issue(3'b111, 32'd5, 32'd0, 5'd13, 0);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);

    issue(3'b100, 32'hFFFF_FC18, 32'd33, 5'd16, 5);
    issue(3'b111, 32'd0, 32'd0, 5'd17, 3);

    // Flush an in-flight divide; nothing may reach the EX/MEM register.
    wait_idle();
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.rd_i = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", {31'h0, bus.busy}, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | bus.valid;
    end
    check("flush_no_valid", {31'h0, seen}, 32'h0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 0);

    for (int i = 0; i < 60; i++) begin
      rand_operand(a);
      rand_operand(b);
      issue(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), (i % 15 == 7) ? 2 : 0);
    end

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Accepts operands from the ID/EX register and drives its result, destination tag and valid into the EX/MEM register that feeds the memory stage.
- Drives `busy`, which the hazard unit ORs into the front-end stall.
- Holds a finished result while the memory stage is stalled on a cache miss.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  in  32  rs1 value.
- src_b  in  32  rs2 value.
- rd_i  in  5  destination register tag.
- flush  in  1  abort the in-flight op (branch mispredict).
- stall_in  in  1  memory-stage stall; while high, DONE holds.
- result  out  32  final value; meaningful only while valid=1.
- rd_o  out  5  latched destination tag.
- valid  out  1  result available to the EX/MEM register.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE; result=0, rd_o=0, valid=0, busy=0; counter, accumulator and operand registers cleared. rst has priority over flush, start and stall_in, including mid-operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch funct3, rd_i, |src_a|, |src_b| and the result-sign flags.
  - Sign rules: DIV/REM and MULH take |x| of both operands; MULHSU takes |x| of src_a only; unsigned ops take operands raw.
  - Special cases go straight to DONE, result set at the same edge.
  - Otherwise go to RUN with counter=0.
- Division special cases (divisor=0):
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → src_a.
- Division special case (signed overflow): src_a=0x80000000, src_b=0xFFFFFFFF.
  - DIV → 0x80000000.
  - REM → 0.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle into a 64-bit product register.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN exit: when counter reaches 31 → DONE. Exactly 32 RUN cycles.
- DONE entry: apply sign fix-up.
  - Product: negate if signs differ.
  - Quotient: negate if signs differ.
  - Remainder: takes the dividend's sign.
  - Select: MUL = product[31:0]; MULH* = product[63:32].
- DONE: valid=1.
  - stall_in=1 → remain in DONE; result and rd_o stable.
  - stall_in=0 → IDLE next edge.
  - A start present in that same DONE cycle is ignored; the issuer holds start until it sees busy=0.
- Latency: start sampled at edge T.
  - Iterative ops: valid high in the cycle after edge T+32.
  - Special cases: valid high in the cycle after edge T.
- start while busy=1: ignored; no operand re-latch.
- flush=1 in RUN or DONE: IDLE next edge, valid=0; the EX/MEM register sees no write.
- flush=1 in IDLE: suppresses a simultaneous start.
- flush beats stall_in.
- busy is registered; it is never combinationally dependent on start.

Optional Feature:
- Macro: FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiply.
  - IDLE→DONE directly; valid one cycle after start.
  - Divides unchanged.
- Undefined: all multiplies take the 32-cycle RUN path; no hardware multiplier is inferred.

Test Plan:
- Reset mid-RUN:
  - start DIVU 100/7, assert rst after 10 cycles.
  - → next cycle: valid=0, busy=0, result=0, rd_o=0.
  - start again → quotient 14 after full latency.
- Signed divide, negative dividend:
  - DIV src_a=0xFFFFFF9C(-100), src_b=7.
  - → valid exactly 33 cycles after start, result=0xFFFFFFF2(-14).
  - REM with same operands → 0xFFFFFFFE(-2).
- Division special cases:
  - DIV x/0 with src_a=5 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
  - Each valid 1 cycle after start.
- Multiply high/low:
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - MUL same operands → 0x00000001.
  - MULHSU 0xFFFFFFFF*2 → 0xFFFFFFFF.
  - Latency 33 cycles without FAST_MUL_EN, 1 cycle with it.
- Stall hold:
  - Hold stall_in=1 for 5 cycles once valid rises.
  - → valid, result and rd_o=rd_i remain constant.
  - IDLE one edge after stall_in drops; start asserted during DONE is ignored.
- Flush abort:
  - Start DIVU, flush at cycle 8.
  - → busy=0 next cycle, valid never asserted.
  - Subsequent MULHU 0xFFFFFFFF*0xFFFFFFFF returns the correct 0xFFFFFFFE.
